// File: rtl/fios_bram_sequencer.sv
// Loads FIOS operands into port A of the shared BRAM, launches the multiplier, and streams the result limbs back out.
// Latency: one write per accepted limb; SETTLE cycles from load to start; 4 cycles per result limb plus consumer stalls.
// Backpressure: op_ready_o is high for the whole load phase; a result limb is held until res_ready_i.
//
// Ports: clock_i/reset_n_i (async active-low); op_* operand limb stream in (n[0..S-1], n'0, X, Y);
//        bram_* port A (byte address, 32-bit data, 4-bit write enable, 2-cycle read latency);
//        fios_reset_o/fios_start_o/fios_done_i drive the FIOS core; res_* result limb stream out;
//        busy_o is high outside IDLE/LOAD; err_timeout_o is a sticky WAIT timeout flag.
// Optional feature: define FIOS_SEQ_TIMEOUT_EN to bound WAIT to TIMEOUT cycles.
module fios_bram_sequencer #(
    parameter int WIDTH   = 256,
    parameter int S       = (WIDTH + 1) / 17 + 1,
    parameter int SETTLE  = 100,
    parameter int TIMEOUT = 8192
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic [16:0] op_data_i,
    output logic [31:0] bram_addr_o,
    output logic [31:0] bram_din_o,
    output logic [3:0]  bram_we_o,
    input  logic [31:0] bram_dout_i,
    output logic        fios_reset_o,
    output logic        fios_start_o,
    input  logic        fios_done_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [16:0] res_data_o,
    output logic        res_last_o,
    output logic        busy_o,
    output logic        err_timeout_o
);
    localparam int NW = 3 * S + 1;
    localparam int KW = $clog2(NW + 1);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SETTLE, ST_START, ST_WAIT, ST_RADDR, ST_RLAT, ST_ROUT
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;          // next operand word to write
    logic [KW-1:0] i_q, i_d;          // result limb being read back
    logic [KW-1:0] widx_q, widx_d;    // word index driven on port A
    logic [SW-1:0] settle_q, settle_d;
    logic          lat_q, lat_d;
    logic          wait_arm_q, wait_arm_d;  // low in the first WAIT cycle to mask a stale done
    logic          op_ready_q, op_ready_d;
    logic [16:0]   din_q, din_d;
    logic          we_q, we_d;
    logic          freset_q, freset_d;
    logic          start_q, start_d;
    logic          res_valid_q, res_valid_d;
    logic [16:0]   res_data_q, res_data_d;
    logic          res_last_q, res_last_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    // Only the low 17 bits of a BRAM word carry a limb.
    logic unused_dout_hi;
    assign unused_dout_hi = ^bram_dout_i[31:17];

`ifdef FIOS_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT > 0);
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        i_d         = i_q;
        widx_d      = widx_q;
        settle_d    = settle_q;
        lat_d       = lat_q;
        wait_arm_d  = wait_arm_q;
        op_ready_d  = op_ready_q;
        din_d       = din_q;
        we_d        = 1'b0;
        freset_d    = freset_q;
        start_d     = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_last_d  = res_last_q;
        err_d       = err_q;
`ifdef FIOS_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d    = ST_LOAD;
                k_d        = '0;
                op_ready_d = 1'b1;
                freset_d   = 1'b1;
            end
            ST_LOAD: begin
                if (op_valid_i && op_ready_q) begin
                    widx_d = k_q;
                    din_d  = op_data_i;
                    we_d   = 1'b1;
                    k_d    = k_q + 1'b1;
                    err_d  = 1'b0;
                    // Last word: its write goes out on this edge, ready drops with it.
                    if (k_q == KW'(NW - 1)) begin
                        state_d    = ST_SETTLE;
                        op_ready_d = 1'b0;
                        freset_d   = 1'b0;
                        settle_d   = '0;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == SW'(SETTLE - 1)) begin
                    state_d = ST_START;
                    start_d = 1'b1;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_START: begin
                state_d    = ST_WAIT;
                wait_arm_d = 1'b0;
`ifdef FIOS_SEQ_TIMEOUT_EN
                tmo_d      = '0;
`endif
            end
            ST_WAIT: begin
                wait_arm_d = 1'b1;
                if (wait_arm_q && fios_done_i) begin
                    state_d = ST_RADDR;
                    i_d     = '0;
                    widx_d  = '0;
                end
`ifdef FIOS_SEQ_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d  = ST_IDLE;
                    freset_d = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_RADDR: begin
                state_d = ST_RLAT;
                lat_d   = 1'b0;
            end
            ST_RLAT: begin
                // Address went out in RADDR; data is on the bus in the second RLAT cycle.
                if (lat_q) begin
                    state_d     = ST_ROUT;
                    res_data_d  = bram_dout_i[16:0];
                    res_valid_d = 1'b1;
                    res_last_d  = (i_q == KW'(S - 1));
                end else begin
                    lat_d = 1'b1;
                end
            end
            ST_ROUT: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                    if (res_last_q) begin
                        state_d  = ST_IDLE;
                        freset_d = 1'b1;
                    end else begin
                        state_d = ST_RADDR;
                        i_d     = i_q + 1'b1;
                        widx_d  = i_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = !((state_d == ST_IDLE) || (state_d == ST_LOAD));
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            i_q         <= '0;
            widx_q      <= '0;
            settle_q    <= '0;
            lat_q       <= 1'b0;
            wait_arm_q  <= 1'b0;
            op_ready_q  <= 1'b0;
            din_q       <= '0;
            we_q        <= 1'b0;
            freset_q    <= 1'b1;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            i_q         <= i_d;
            widx_q      <= widx_d;
            settle_q    <= settle_d;
            lat_q       <= lat_d;
            wait_arm_q  <= wait_arm_d;
            op_ready_q  <= op_ready_d;
            din_q       <= din_d;
            we_q        <= we_d;
            freset_q    <= freset_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
            busy_q      <= busy_d;
        end
    end

`ifdef FIOS_SEQ_TIMEOUT_EN
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    assign err_q = 1'b0;
`endif

    assign op_ready_o    = op_ready_q;
    assign bram_addr_o   = {{(30 - KW){1'b0}}, widx_q, 2'b00};
    assign bram_din_o    = {15'b0, din_q};
    assign bram_we_o     = {4{we_q}};
    assign fios_reset_o  = freset_q;
    assign fios_start_o  = start_q;
    assign res_valid_o   = res_valid_q;
    assign res_data_o    = res_data_q;
    assign res_last_o    = res_last_q;
    assign busy_o        = busy_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_fios_bram_sequencer.sv
module tb_fios_bram_sequencer;
    localparam int WIDTH   = 256;
    localparam int S       = 16;
    localparam int SETTLE  = 100;
    localparam int TIMEOUT = 8192;
    localparam int NW      = 3 * S + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid_i = 1'b0;
    logic        op_ready_o;
    logic [16:0] op_data_i = '0;
    logic [31:0] bram_addr_o, bram_din_o, bram_dout_i;
    logic [3:0]  bram_we_o;
    logic        fios_reset_o, fios_start_o, fios_done_i;
    logic        res_valid_o;
    logic        res_ready_i = 1'b1;
    logic [16:0] res_data_o;
    logic        res_last_o, busy_o, err_timeout_o;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    fios_bram_sequencer #(.WIDTH(WIDTH), .S(S), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clock_i(clk), .reset_n_i(rst_n),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_data_i(op_data_i),
        .bram_addr_o(bram_addr_o), .bram_din_o(bram_din_o), .bram_we_o(bram_we_o),
        .bram_dout_i(bram_dout_i),
        .fios_reset_o(fios_reset_o), .fios_start_o(fios_start_o), .fios_done_i(fios_done_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_last_o(res_last_o), .busy_o(busy_o), .err_timeout_o(err_timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // BRAM with 2-cycle read latency, plus a FIOS stand-in that writes
    // res[j] = n[j] + X[j] + Y[j] (mod 2^17) into words 0..S-1 and raises done.
    logic [31:0] mem [0:63];
    logic [31:0] rd1 = '0, rd2 = '0;
    logic done_r = 1'b0, fbusy = 1'b0, start_d1 = 1'b0;
    logic force_done = 1'b0, never_done = 1'b0;
    int   fcnt = 0;
    assign fios_done_i = done_r | force_done;
    assign bram_dout_i = rd2;

    always @(posedge clk) begin
        if (bram_we_o == 4'hF) mem[bram_addr_o[7:2]] <= bram_din_o;
        rd1      <= mem[bram_addr_o[7:2]];
        rd2      <= rd1;
        start_d1 <= fios_start_o;
        if (fios_reset_o) begin
            done_r <= 1'b0;
            fbusy  <= 1'b0;
        end else if (start_d1) begin
            done_r <= 1'b0;
            fbusy  <= !never_done;
            fcnt   <= 20;
        end else if (fbusy) begin
            if (fcnt == 0) begin
                fbusy  <= 1'b0;
                done_r <= 1'b1;
                for (int j = 0; j < S; j++)
                    mem[j] <= {15'b0, 17'(mem[j][16:0] + mem[S+1+j][16:0] + mem[2*S+1+j][16:0])};
            end else begin
                fcnt <= fcnt - 1;
            end
        end
    end

    // Monitor: port-A writes must follow handshakes one-for-one at contiguous
    // addresses; result limbs are popped from the scoreboard on each handshake.
    logic        prev_hs = 1'b0, prev_rdy = 1'b0;
    logic [16:0] prev_dat = '0;
    int          wr_idx = 0, cyc = 0, first_wr = 0, last_wr = 0, popped = 0;
    logic        hold_vld = 1'b0;
    logic [16:0] hold_dat = '0;
    logic [17:0] exp_q [$];

    always @(negedge clk) begin
        logic [17:0] e;
        cyc++;
        if (op_ready_o && !prev_rdy) wr_idx = 0;
        check("wr_en", {28'b0, bram_we_o}, prev_hs ? 32'hF : 32'h0);
        if (prev_hs) begin
            check("wr_addr", bram_addr_o, 32'(wr_idx * 4));
            check("wr_data", bram_din_o, {15'b0, prev_dat});
            if (wr_idx == 0) first_wr = cyc;
            last_wr = cyc;
            wr_idx++;
        end
        if (hold_vld) begin
            check("res_held_vld", {31'b0, res_valid_o}, 32'h1);
            check("res_held_dat", {15'b0, res_data_o}, {15'b0, hold_dat});
        end
        hold_vld = 1'b0;
        if (res_valid_o) begin
            if (res_ready_i) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("res_limb", {14'b0, res_last_o, res_data_o}, {14'b0, e});
                end else begin
                    check("res_extra_limb", {14'b0, res_last_o, res_data_o}, 32'hFFFF_FFFF);
                end
                popped++;
            end else begin
                hold_vld = 1'b1;
                hold_dat = res_data_o;
            end
        end
        prev_hs  = op_valid_i & op_ready_o;
        prev_rdy = op_ready_o;
        prev_dat = op_data_i;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_op_ready"}, {31'b0, op_ready_o}, 32'h0);
        check({tag, "_addr"}, bram_addr_o, 32'h0);
        check({tag, "_din"}, bram_din_o, 32'h0);
        check({tag, "_we"}, {28'b0, bram_we_o}, 32'h0);
        check({tag, "_fios_reset"}, {31'b0, fios_reset_o}, 32'h1);
        check({tag, "_start"}, {31'b0, fios_start_o}, 32'h0);
        check({tag, "_res_valid"}, {31'b0, res_valid_o}, 32'h0);
        check({tag, "_res_data"}, {15'b0, res_data_o}, 32'h0);
        check({tag, "_res_last"}, {31'b0, res_last_o}, 32'h0);
        check({tag, "_busy"}, {31'b0, busy_o}, 32'h0);
        check({tag, "_err"}, {31'b0, err_timeout_o}, 32'h0);
    endtask

    // One load/launch/readback run. gaps: random idle cycles between limbs;
    // toggle: res_ready_i alternates; stale: done held high through START and
    // the first WAIT cycle; abort: reset pulsed during WAIT; expect_done: results read.
    task automatic do_run(input bit gaps, input bit toggle, input bit stale,
                          input bit abort, input bit expect_done);
        logic [16:0] limbs [NW];
        int base, bud, scnt;
        logic got;
        for (int w = 0; w < NW; w++) limbs[w] = 17'($urandom);
        if (expect_done && !abort)
            for (int j = 0; j < S; j++)
                exp_q.push_back({(j == S - 1), 17'(limbs[j] + limbs[S+1+j] + limbs[2*S+1+j])});
        base = popped;
        force_done = stale;
        for (int w = 0; w < NW; w++) begin
            if (gaps) begin
                op_valid_i = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            op_valid_i = 1'b1;
            op_data_i  = limbs[w];
            bud = 0;
            do begin
                @(negedge clk); got = op_ready_o;
                @(posedge clk); #1; bud++;
            end while (!got && bud < 200);
            if (!got) check("load_handshake_budget", 32'(bud), 32'h0);
            if (w == 0) check("err_clear_on_load", {31'b0, err_timeout_o}, 32'h0);
        end
        op_valid_i = 1'b0;
        scnt = 0; bud = 0;
        do begin
            @(negedge clk);
            if (!fios_start_o && !fios_reset_o) scnt++;
            bud++;
        end while (!fios_start_o && bud < 1000);
        check("settle_cycles", 32'(scnt), 32'(SETTLE));
        check("load_writes", 32'(wr_idx), 32'(NW));
        if (!gaps) check("load_span", 32'(last_wr - first_wr), 32'(NW - 1));
        check("busy_in_start", {31'b0, busy_o}, 32'h1);
        @(posedge clk); #1;
        check("start_pulse_width", {31'b0, fios_start_o}, 32'h0);
        @(posedge clk); #1;
        force_done = 1'b0;
        if (abort) begin
            repeat (4) @(posedge clk);
            #2 rst_n = 1'b0;
            @(negedge clk);
            check_reset_vals("abort");
            @(posedge clk); #1 rst_n = 1'b1;
            return;
        end
        if (expect_done) begin
            bud = 0;
            while (popped < base + S && bud < 3000) begin
                @(posedge clk); #1;
                res_ready_i = toggle ? ~res_ready_i : 1'b1;
                bud++;
            end
            check("res_count", 32'(popped - base), 32'(S));
            @(negedge clk);
            check("end_fios_reset", {31'b0, fios_reset_o}, 32'h1);
            check("end_busy", {31'b0, busy_o}, 32'h0);
            res_ready_i = 1'b1;
        end
    endtask

    initial begin
        int bud;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1 rst_n = 1'b1;

        do_run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // back-to-back limbs, consumer always ready
        do_run(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);   // stale done, ready toggling
        do_run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // random valid gaps
        do_run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);   // reset pulsed in WAIT
        do_run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // full run after the abort
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

`ifdef FIOS_SEQ_TIMEOUT_EN
        never_done = 1'b1;
        do_run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bud = 0;
        while (busy_o && bud < TIMEOUT + 100) begin @(negedge clk); bud++; end
        check("tmo_err", {31'b0, err_timeout_o}, 32'h1);
        check("tmo_fios_reset", {31'b0, fios_reset_o}, 32'h1);
        check("tmo_busy", {31'b0, busy_o}, 32'h0);
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", {31'b0, err_timeout_o}, 32'h1);
        never_done = 1'b0;
        do_run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        bud = 0;
        check("err_tied_low", {31'b0, err_timeout_o}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed no completion, required finish within budget");
        $fatal(1, "watchdog expired");
    end

endmodule
